// File: rtl/dp_bank_arbiter.sv
// Bank decoder and conflict arbiter for a two-port, multi-bank memory.
// Decodes the bank from the address MSBs and grants one port when both hit the same bank.
module dp_bank_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int NUM_BANK  = 4,
    parameter int BANK_W    = $clog2(NUM_BANK),
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       a_req,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic                       a_we,
    output logic                       a_gnt,
    output logic [NUM_BANK-1:0]        a_bank_en,
    output logic [ADDR_W-BANK_W-1:0]   a_row,
    output logic                       a_we_q,
    output logic                       a_err,

    input  logic                       b_req,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic                       b_we,
    output logic                       b_gnt,
    output logic [NUM_BANK-1:0]        b_bank_en,
    output logic [ADDR_W-BANK_W-1:0]   b_row,
    output logic                       b_we_q,
    output logic                       b_err,

    output logic [CNT_W-1:0]           conflict_cnt,
    output logic                       prio_state
);

    localparam int ROW_W = ADDR_W - BANK_W;

    // Handshake: a port's request is accepted in any cycle where req and gnt are
    // both high. A port seeing req without gnt must hold req and addr stable; the
    // block keeps no queue, so a dropped request is simply never serviced.

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t prio_q;
    prio_t prio_d;

    logic [BANK_W-1:0] a_idx;
    logic [BANK_W-1:0] b_idx;
    logic              a_in_range;
    logic              b_in_range;
    logic              conflict;

    assign a_idx      = a_addr[ADDR_W-1 -: BANK_W];
    assign b_idx      = b_addr[ADDR_W-1 -: BANK_W];
    assign a_in_range = (int'(a_idx) < NUM_BANK);
    assign b_in_range = (int'(b_idx) < NUM_BANK);

    // An out-of-range index is consumed with an error and never contends for a bank.
    assign conflict = a_req && b_req && (a_idx == b_idx) && a_in_range;

    assign prio_state = prio_q;

    always_comb begin
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        prio_d = prio_q;
        if (!rst) begin
            if (conflict) begin
                if (PRIO_MODE != 0 || prio_q == PRIO_A) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
                // Winner was prio_q, so toggling points the flag at the loser.
                if (PRIO_MODE == 0) begin
                    prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= PRIO_A;
            a_bank_en    <= '0;
            a_row        <= '0;
            a_we_q       <= 1'b0;
            a_err        <= 1'b0;
            b_bank_en    <= '0;
            b_row        <= '0;
            b_we_q       <= 1'b0;
            b_err        <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            prio_q <= prio_d;

            a_bank_en <= (a_gnt && a_in_range) ? (NUM_BANK'(1) << a_idx) : '0;
            a_we_q    <= a_gnt && a_we;
            a_err     <= a_gnt && !a_in_range;
            if (a_gnt) begin
                a_row <= a_addr[ROW_W-1:0];
            end

            b_bank_en <= (b_gnt && b_in_range) ? (NUM_BANK'(1) << b_idx) : '0;
            b_we_q    <= b_gnt && b_we;
            b_err     <= b_gnt && !b_in_range;
            if (b_gnt) begin
                b_row <= b_addr[ROW_W-1:0];
            end

            if (conflict && conflict_cnt != {CNT_W{1'b1}}) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
